// File: rtl/irq_ctrl_if.sv
// Bus bundle between the SoC interrupt sources / core and irq_ctrl.
// master drives lines, mask writes and core handshakes; slave is the controller.
interface irq_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) ();
    logic [N_IRQ-1:0] irq_i;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wd;
    logic             irq_ack;
    logic             ERet;
    logic             ExtIRQ;
    logic [ID_W-1:0]  irq_id;
    logic             in_service;
    logic [N_IRQ-1:0] pending;

    modport master (
        output irq_i, mask_we, mask_wd, irq_ack, ERet,
        input  ExtIRQ, irq_id, in_service, pending
    );

    modport slave (
        input  irq_i, mask_we, mask_wd, irq_ack, ERet,
        output ExtIRQ, irq_id, in_service, pending
    );
endinterface

// File: rtl/irq_ctrl.sv
// Multi-line external interrupt controller: edge capture, mask, fixed priority, request/service handshake.
// Define IRQ_SYNC_EN to insert a 2-flop synchroniser on every irq_i bit.
module irq_ctrl #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input logic     clk,
    input logic     reset,
    irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [N_IRQ-1:0] ZERO_V = {N_IRQ{1'b0}};

    logic [N_IRQ-1:0] line_s;
    logic [N_IRQ-1:0] rise_s;
    logic [N_IRQ-1:0] sel_s;
    logic [N_IRQ-1:0] clr_s;
    logic [N_IRQ-1:0] edge_r;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] mask_r;
    state_t           state_r;
    logic             ext_irq_r;
    logic             in_service_r;
    logic [ID_W-1:0]  irq_id_r;

    // Lowest set index wins; returns 0 for an empty vector.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            idx = v[i] ? ID_W'(i) : idx;
        end
        return idx;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;

    // Two-flop synchroniser for asynchronous interrupt sources
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= ZERO_V;
            sync2_r <= ZERO_V;
        end else begin
            sync1_r <= bus.irq_i;
            sync2_r <= sync1_r;
        end
    end

    assign line_s = sync2_r;
`else
    assign line_s = bus.irq_i;
`endif

    // Rising-edge detect, selection and acknowledge clear mask
    always_comb begin
        rise_s = line_s & ~edge_r;
        sel_s  = pending_r & mask_r;
        clr_s  = ZERO_V;
        if ((state_r == REQ) && bus.irq_ack) begin
            clr_s = N_IRQ'(1'b1) << irq_id_r;
        end else begin
            clr_s = ZERO_V;
        end
    end

    // Edge-detect history, pending bits (a new edge beats the ack clear) and mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_r    <= ZERO_V;
            pending_r <= ZERO_V;
            mask_r    <= ZERO_V;
        end else begin
            edge_r    <= line_s;
            pending_r <= (pending_r & ~clr_s) | rise_s;
            if (bus.mask_we) begin
                mask_r <= bus.mask_wd;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Request/service handshake; a raised request is held until acknowledged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            ext_irq_r    <= 1'b0;
            in_service_r <= 1'b0;
            irq_id_r     <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_s != ZERO_V) begin
                        state_r   <= REQ;
                        ext_irq_r <= 1'b1;
                        irq_id_r  <= lowest_idx(sel_s);
                    end else begin
                        state_r   <= IDLE;
                        ext_irq_r <= 1'b0;
                    end
                    in_service_r <= 1'b0;
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        state_r      <= SERVICE;
                        ext_irq_r    <= 1'b0;
                        in_service_r <= 1'b1;
                    end else begin
                        state_r      <= REQ;
                        ext_irq_r    <= 1'b1;
                        in_service_r <= 1'b0;
                    end
                end
                SERVICE: begin
                    // No direct SERVICE->REQ: one IDLE cycle always separates handlers
                    if (bus.ERet) begin
                        state_r      <= IDLE;
                        in_service_r <= 1'b0;
                    end else begin
                        state_r      <= SERVICE;
                        in_service_r <= 1'b1;
                    end
                    ext_irq_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    ext_irq_r    <= 1'b0;
                    in_service_r <= 1'b0;
                    irq_id_r     <= {ID_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.ExtIRQ     = ext_irq_r;
    assign bus.irq_id     = irq_id_r;
    assign bus.in_service = in_service_r;
    assign bus.pending    = pending_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_irq_ctrl;
    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    irq_ctrl_if #(.N_IRQ(N), .ID_W(IDW)) bus ();
    irq_ctrl #(.N_IRQ(N), .ID_W(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic           ext;
        logic [IDW-1:0] id;
        logic           svc;
        logic [N-1:0]   pend;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int passed = 0;

    // model state: pending set, mask, phase (0 idle, 1 requesting, 2 in handler)
    logic [N-1:0]   m_pend, m_mask, m_prev;
    int             m_phase;
    logic [IDW-1:0] m_id;
    logic [N-1:0]   line_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_phase = 0; m_id = '0;
        line_q.delete();
        for (int i = 0; i < SYNC; i++) line_q.push_back('0);
        sb_q.delete();
    endtask

    // One clock edge of the specified behaviour; pushes the expected post-edge outputs
    task automatic model_edge(input logic [N-1:0] irq, input logic we, input logic [N-1:0] wd,
                              input logic ack, input logic eret);
        logic [N-1:0] line, rise, sel, clr;
        exp_t e;
        line_q.push_back(irq);
        line = line_q.pop_front();
        rise = line & ~m_prev;
        m_prev = line;
        sel = m_pend & m_mask;
        clr = '0;
        case (m_phase)
            0: if (sel != 0) begin m_phase = 1; m_id = IDW'(lowest(sel)); end
            1: if (ack) begin m_phase = 2; clr[m_id] = 1'b1; end
            2: if (eret) m_phase = 0;
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        if (we) m_mask = wd;
        e.ext = (m_phase == 1); e.id = m_id; e.svc = (m_phase == 2); e.pend = m_pend;
        sb_q.push_back(e);
    endtask

    // Called 2 time units after a rising edge; drives inputs for the next edge
    task automatic step(input logic [N-1:0] irq, input logic we, input logic [N-1:0] wd,
                        input logic ack, input logic eret);
        bus.irq_i = irq; bus.mask_we = we; bus.mask_wd = wd; bus.irq_ack = ack; bus.ERet = eret;
        model_edge(irq, we, wd, ack, eret);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_ext(input string name);
        int cnt;
        cnt = 0;
        while (bus.ExtIRQ !== 1'b1 && cnt < 12) begin
            idle(1);
            cnt++;
        end
        check(name, bus.ExtIRQ, 1);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next edge
    task automatic do_reset(input logic [N-1:0] irq_hold);
        #1;
        reset = 1'b0;
        sb_q.delete();
        bus.irq_i = irq_hold; bus.mask_we = 1'b0; bus.mask_wd = '0; bus.irq_ack = 1'b0; bus.ERet = 1'b0;
        #1;
        check("rst_ext", bus.ExtIRQ, 0);
        check("rst_svc", bus.in_service, 0);
        check("rst_pend", bus.pending, 0);
        check("rst_id", bus.irq_id, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            bus.irq_i = (i % 2 == 0) ? '0 : irq_hold;
        end
        #2;
        bus.irq_i = '0;
        reset = 1'b1;
        model_reset();
        check("rel_pend", bus.pending, 0);
    endtask

    // Scoreboard monitor: one expectation per edge, compared 1 unit after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("ExtIRQ", bus.ExtIRQ, e.ext);
            check("in_service", bus.in_service, e.svc);
            check("pending", bus.pending, e.pend);
            if (e.ext || e.svc) check("irq_id", bus.irq_id, e.id);
        end
    end

    initial begin
        logic [N-1:0] cur;
        int cnt;
        bus.irq_i = '0; bus.mask_we = 1'b0; bus.mask_wd = '0; bus.irq_ack = 1'b0; bus.ERet = 1'b0;
        model_reset();
        @(posedge clk);
        #2;

        // Reset with lines toggling, then edges with mask=0: pending only
        do_reset(4'hF);
        step(4'b0101, 1'b0, '0, 1'b0, 1'b0);
        idle(6);
        check("mask0_noreq", bus.ExtIRQ, 0);
        check("mask0_pend", bus.pending, 4'b0101);

        // Latency from a single pulse on line 2
        do_reset('0);
        step('0, 1'b1, 4'hF, 1'b0, 1'b0);
        step(4'b0100, 1'b0, '0, 1'b0, 1'b0);
        cnt = 0;
        while (bus.ExtIRQ !== 1'b1 && cnt < 10) begin
            idle(1);
            cnt++;
        end
        check("latency", cnt, SYNC + 1);
        check("lat_id", bus.irq_id, 2);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        step('0, 1'b0, '0, 1'b0, 1'b1);
        idle(2);

        // Priority: lines 3 and 1 together
        do_reset('0);
        step('0, 1'b1, 4'hF, 1'b0, 1'b0);
        step(4'b1010, 1'b0, '0, 1'b0, 1'b0);
        wait_ext("prio_wait");
        check("prio_id", bus.irq_id, 1);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        step('0, 1'b0, '0, 1'b0, 1'b1);
        check("eret_gap", bus.ExtIRQ, 0);
        wait_ext("prio_wait2");
        check("prio_id2", bus.irq_id, 3);

        // No retraction: line 0 arrives and mask drops line 3 while requesting 3
        step(4'b0001, 1'b1, 4'b0111, 1'b0, 1'b0);
        idle(SYNC + 4);
        check("noretract_ext", bus.ExtIRQ, 1);
        check("noretract_id", bus.irq_id, 3);
        step('0, 1'b0, '0, 1'b1, 1'b0);
        step('0, 1'b0, '0, 1'b0, 1'b1);
        wait_ext("line0_wait");
        check("line0_id", bus.irq_id, 0);

        // Set-wins race: new edge on line 0 reaches detection on the ack edge
        for (int j = 0; j <= SYNC; j++) step(4'b0001, 1'b0, '0, (j == SYNC), 1'b0);
        idle(2);
        check("race_pend", bus.pending[0], 1);
        step('0, 1'b0, '0, 1'b0, 1'b1);
        wait_ext("race_rereq");
        check("race_id", bus.irq_id, 0);
        step('0, 1'b0, '0, 1'b1, 1'b0);

        // Reset while in service with a pending line
        step(4'b0010, 1'b0, '0, 1'b0, 1'b0);
        idle(SYNC + 2);
        check("pre_rst_svc", bus.in_service, 1);
        do_reset('0);

        // Random traffic
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            logic we, ack, eret;
            logic [N-1:0] wd;
            if ($urandom_range(0, 2) == 0) cur = cur ^ N'($urandom_range(0, 15));
            we   = ($urandom_range(0, 15) == 0);
            wd   = N'($urandom_range(0, 15));
            ack  = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            eret = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step(cur, we, wd, ack, eret);
            if ($urandom_range(0, 599) == 0) begin
                do_reset('0);
                cur = '0;
            end
        end
        idle(2);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
